// File: rtl/hit_roll_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hit_roll_unit_pkg
// Purpose  : Shared game types and constants. Used by the hit roll unit and
//            by the other LFSR consumers (opponent and level generators).
// Revision : 1.0  initial release
// ============================================================================
package hit_roll_unit_pkg;

  // Width of a roll value and of a percentage value
  localparam int ROLL_W        = 7;
  // Default exclusive upper bound of a roll
  localparam int RANGE_DEFAULT = 100;

  // Hit chance expressed in units of the roll range
  typedef logic [ROLL_W-1:0] pct_t;

  // Roll sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage : hit_roll_unit_pkg
`default_nettype wire

// File: rtl/hit_roll_unit_rng_sample_filter.sv
`default_nettype none
// ============================================================================
// Module   : rng_sample_filter
// Purpose  : Combinational helper. Folds the 16-bit LFSR state into a 7-bit
//            sample, flags whether that sample lies inside the roll range,
//            and provides the folded-down fallback value for rejected samples.
// Revision : 1.0  initial release
// ============================================================================
module rng_sample_filter
  import hit_roll_unit_pkg::*;
#(
  parameter int RANGE = RANGE_DEFAULT
) (
  input  logic [15:0]       i_rng,
  output logic [ROLL_W-1:0] o_samp,
  output logic              o_accept,
  output logic [ROLL_W-1:0] o_fallback
);

  // Gap between the raw 7-bit space and the roll range
  localparam logic [ROLL_W-1:0] c_OFFSET = ROLL_W'(128 - RANGE);
  // Range held one bit wider so RANGE=128 is representable
  localparam logic [ROLL_W:0]   c_RANGE  = (ROLL_W + 1)'(RANGE);

  // Bits 8:7 do not take part in the fold
  logic w_unused_bits;
  assign w_unused_bits = ^i_rng[8:7];

  // Fold the two 7-bit fields so consecutive shift states decorrelate
  always_comb begin
    o_samp     = i_rng[6:0] ^ i_rng[15:9];
    o_accept   = ({1'b0, o_samp} < c_RANGE);
    // Only consumed when the sample was rejected, so it never underflows
    o_fallback = o_samp - c_OFFSET;
  end

endmodule : rng_sample_filter
`default_nettype wire

// File: rtl/hit_roll_unit.sv
`default_nettype none
// ============================================================================
// Module   : hit_roll_unit
// Purpose  : Turns the free-running LFSR value into one hit/miss decision
//            against a requested hit rate. The roll is drawn by rejection
//            sampling with bounded retries, and the result is returned
//            through a req/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module hit_roll_unit
  import hit_roll_unit_pkg::*;
#(
  parameter int RANGE     = RANGE_DEFAULT,
  parameter int MAX_TRIES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       rng,
  input  logic              req,
  input  pct_t              hit_pct,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [ROLL_W-1:0] roll
);

  localparam logic [3:0]        c_LAST_TRY = 4'(MAX_TRIES - 1);
  localparam logic [ROLL_W:0]   c_RANGE    = (ROLL_W + 1)'(RANGE);

  state_t              r_state;
  logic [3:0]          r_tries;
  logic [ROLL_W:0]     r_pct;      // one bit wider so a saturated RANGE=128 fits
  logic                r_busy;
  logic                r_done;
  logic                r_hit;
  logic [ROLL_W-1:0]   r_roll;

  logic [ROLL_W-1:0]   w_samp;
  logic                w_accept;
  logic [ROLL_W-1:0]   w_fallback;
  logic [ROLL_W-1:0]   w_final;
  logic [ROLL_W:0]     w_pct_sat;
  logic                w_finish;

  rng_sample_filter #(
    .RANGE (RANGE)
  ) u_filter (
    .i_rng      (rng),
    .o_samp     (w_samp),
    .o_accept   (w_accept),
    .o_fallback (w_fallback)
  );

  // Saturate the requested rate, pick the final roll, and decide when sampling ends
  always_comb begin
    w_pct_sat = ({1'b0, hit_pct} > c_RANGE) ? c_RANGE : {1'b0, hit_pct};
    w_final   = w_accept ? w_samp : w_fallback;
    w_finish  = w_accept || (r_tries == c_LAST_TRY);
  end

  // Roll sequencer with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tries <= '0;
      r_pct   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hit   <= 1'b0;
      r_roll  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (req) begin
            r_pct   <= w_pct_sat;
            r_tries <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (w_finish) begin
            r_roll  <= w_final;
            r_hit   <= ({1'b0, w_final} < r_pct);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_tries <= r_tries + 4'd1;
          end
        end
        ST_DONE: begin
          // Single-cycle result strobe; requests here are dropped
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hit  = r_hit;
  assign roll = r_roll;

endmodule : hit_roll_unit
`default_nettype wire
